// File: rtl/csr_unit.sv
// csr_unit: machine-mode CSR file with cycle/instret counters, trap entry/return and interrupt status.
// Defining CSR_TIMER_EN adds mtime/mtimecmp and drives mip.MTIP; otherwise no timer flops exist.
module csr_unit #(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] MTVEC_RST = '0,
  parameter logic [XLEN-1:0] HART_ID   = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [11:0]     raddr,
  output logic [XLEN-1:0] rdata,
  output logic            rillegal,
  input  logic            we,
  input  logic [11:0]     waddr,
  input  logic [XLEN-1:0] wdata,
  input  logic            trap_valid,
  input  logic [XLEN-1:0] trap_cause,
  input  logic [XLEN-1:0] trap_pc,
  input  logic [XLEN-1:0] trap_tval,
  input  logic            mret,
  input  logic            retire,
  input  logic            ext_irq,
  input  logic            sw_irq,
  output logic [XLEN-1:0] trap_target,
  output logic [XLEN-1:0] mepc_o,
  output logic            irq_pending,
  output logic [XLEN-1:0] irq_cause
);

  localparam logic [11:0] A_MSTATUS   = 12'h300;
  localparam logic [11:0] A_MIE       = 12'h304;
  localparam logic [11:0] A_MTVEC     = 12'h305;
  localparam logic [11:0] A_MSCRATCH  = 12'h340;
  localparam logic [11:0] A_MEPC      = 12'h341;
  localparam logic [11:0] A_MCAUSE    = 12'h342;
  localparam logic [11:0] A_MTVAL     = 12'h343;
  localparam logic [11:0] A_MIP       = 12'h344;
  localparam logic [11:0] A_MCYCLE    = 12'hB00;
  localparam logic [11:0] A_MINSTRET  = 12'hB02;
  localparam logic [11:0] A_MCYCLEH   = 12'hB80;
  localparam logic [11:0] A_MINSTRETH = 12'hB82;
  localparam logic [11:0] A_MHARTID   = 12'hF14;
  localparam logic [11:0] A_MTIME     = 12'h7C0;
  localparam logic [11:0] A_MTIMEH    = 12'h7C1;
  localparam logic [11:0] A_MTIMECMP  = 12'h7C2;
  localparam logic [11:0] A_MTIMECMPH = 12'h7C3;

  localparam logic [XLEN-1:0] EPC_MASK  = {{(XLEN-2){1'b1}}, 2'b00};
  localparam logic [XLEN-1:0] CAUSE_MEI = {1'b1, {(XLEN-5){1'b0}}, 4'd11};
  localparam logic [XLEN-1:0] CAUSE_MSI = {1'b1, {(XLEN-5){1'b0}}, 4'd3};
  localparam logic [XLEN-1:0] CAUSE_MTI = {1'b1, {(XLEN-5){1'b0}}, 4'd7};

  function automatic logic impl_addr(input logic [11:0] a);
    case (a)
      A_MSTATUS, A_MIE, A_MTVEC, A_MSCRATCH, A_MEPC, A_MCAUSE, A_MTVAL, A_MIP,
      A_MCYCLE, A_MINSTRET, A_MHARTID: return 1'b1;
      A_MCYCLEH, A_MINSTRETH:          return (XLEN == 32);
`ifdef CSR_TIMER_EN
      A_MTIME, A_MTIMECMP:             return 1'b1;
      A_MTIMEH, A_MTIMECMPH:           return (XLEN == 32);
`endif
      default:                         return 1'b0;
    endcase
  endfunction

  function automatic logic wr_ok(input logic [11:0] a);
    return impl_addr(a) && (a != A_MIP) && (a != A_MHARTID);
  endfunction

  // Value a write would leave behind, as seen by a subsequent read.
  function automatic logic [XLEN-1:0] wmask(input logic [11:0] a, input logic [XLEN-1:0] d);
    case (a)
      A_MSTATUS: return d & XLEN'(32'h88);
      A_MIE:     return d & XLEN'(32'h888);
      A_MEPC:    return d & EPC_MASK;
      default:   return d;
    endcase
  endfunction

  logic            st_mie, st_mpie;
  logic            msie, mtie, meie;
  logic            msip, mtip, meip;
  logic [XLEN-1:0] mtvec, mscratch, mepc, mcause, mtval;
  logic [63:0]     mcycle, minstret;
  logic [XLEN-1:0] mie_vec, mip_vec, pend, base;
  logic            sw_we;

  assign sw_we  = we && wr_ok(waddr);
  assign mepc_o = mepc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_mie   <= 1'b0;
      st_mpie  <= 1'b0;
      msie     <= 1'b0;
      mtie     <= 1'b0;
      meie     <= 1'b0;
      msip     <= 1'b0;
      meip     <= 1'b0;
      mtvec    <= MTVEC_RST;
      mscratch <= '0;
      mepc     <= '0;
      mcause   <= '0;
      mtval    <= '0;
    end else begin
      meip <= ext_irq;
      msip <= sw_irq;
      if (trap_valid) begin
        mepc    <= trap_pc & EPC_MASK;
        mcause  <= trap_cause;
        mtval   <= trap_tval;
        st_mpie <= st_mie;
        st_mie  <= 1'b0;
      end else if (mret) begin
        st_mie  <= st_mpie;
        st_mpie <= 1'b1;
      end
      // Software writes lose to any trap/mret that touches the same register.
      if (sw_we) begin
        case (waddr)
          A_MSTATUS: if (!trap_valid && !mret) begin
            st_mie  <= wdata[3];
            st_mpie <= wdata[7];
          end
          A_MIE: begin
            msie <= wdata[3];
            mtie <= wdata[7];
            meie <= wdata[11];
          end
          A_MTVEC:    mtvec    <= wdata;
          A_MSCRATCH: mscratch <= wdata;
          A_MEPC:     if (!trap_valid) mepc   <= wdata & EPC_MASK;
          A_MCAUSE:   if (!trap_valid) mcause <= wdata;
          A_MTVAL:    if (!trap_valid) mtval  <= wdata;
          default: ;
        endcase
      end
    end
  end

  // A write to either half of a counter suppresses that counter's increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcycle   <= '0;
      minstret <= '0;
    end else begin
      if (sw_we && waddr == A_MCYCLE) begin
        if (XLEN == 64) mcycle <= 64'(wdata);
        else            mcycle[31:0] <= wdata[31:0];
      end else if (sw_we && waddr == A_MCYCLEH) begin
        mcycle[63:32] <= wdata[31:0];
      end else begin
        mcycle <= mcycle + 64'd1;
      end
      if (sw_we && waddr == A_MINSTRET) begin
        if (XLEN == 64) minstret <= 64'(wdata);
        else            minstret[31:0] <= wdata[31:0];
      end else if (sw_we && waddr == A_MINSTRETH) begin
        minstret[63:32] <= wdata[31:0];
      end else if (retire) begin
        minstret <= minstret + 64'd1;
      end
    end
  end

`ifdef CSR_TIMER_EN
  logic [63:0] mtime, mtimecmp;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mtime    <= '0;
      mtimecmp <= '0;
      mtip     <= 1'b0;
    end else begin
      mtip <= (mtime >= mtimecmp) && (mtimecmp != 64'd0);
      if (sw_we && waddr == A_MTIME) begin
        if (XLEN == 64) mtime <= 64'(wdata);
        else            mtime[31:0] <= wdata[31:0];
      end else if (sw_we && waddr == A_MTIMEH) begin
        mtime[63:32] <= wdata[31:0];
      end else begin
        mtime <= mtime + 64'd1;
      end
      if (sw_we && waddr == A_MTIMECMP) begin
        if (XLEN == 64) mtimecmp <= 64'(wdata);
        else            mtimecmp[31:0] <= wdata[31:0];
      end else if (sw_we && waddr == A_MTIMECMPH) begin
        mtimecmp[63:32] <= wdata[31:0];
      end
    end
  end
`else
  assign mtip = 1'b0;
`endif

  always_comb begin
    mie_vec     = '0;
    mie_vec[3]  = msie;
    mie_vec[7]  = mtie;
    mie_vec[11] = meie;
    mip_vec     = '0;
    mip_vec[3]  = msip;
    mip_vec[7]  = mtip;
    mip_vec[11] = meip;
    pend        = mie_vec & mip_vec;
    irq_pending = st_mie & (|pend);
    irq_cause   = '0;
    if (irq_pending) begin
      if (pend[11])     irq_cause = CAUSE_MEI;
      else if (pend[3]) irq_cause = CAUSE_MSI;
      else              irq_cause = CAUSE_MTI;
    end
  end

  always_comb begin
    base        = mtvec & EPC_MASK;
    trap_target = base;
    if (trap_valid) begin
      if (mtvec[1:0] == 2'b01 && trap_cause[XLEN-1])
        trap_target = base + XLEN'({trap_cause[XLEN-2:0], 2'b00});
    end else if (mret) begin
      trap_target = mepc;
    end
  end

  always_comb begin
    rdata    = '0;
    rillegal = !impl_addr(raddr);
    if (we && waddr == raddr && wr_ok(raddr)) begin
      rdata = wmask(raddr, wdata);
    end else begin
      case (raddr)
        A_MSTATUS:   rdata = XLEN'({st_mpie, 3'b000, st_mie, 3'b000});
        A_MIE:       rdata = mie_vec;
        A_MTVEC:     rdata = mtvec;
        A_MSCRATCH:  rdata = mscratch;
        A_MEPC:      rdata = mepc;
        A_MCAUSE:    rdata = mcause;
        A_MTVAL:     rdata = mtval;
        A_MIP:       rdata = mip_vec;
        A_MCYCLE:    rdata = XLEN'(mcycle);
        A_MINSTRET:  rdata = XLEN'(minstret);
        A_MCYCLEH:   if (XLEN == 32) rdata = XLEN'(mcycle[63:32]);
        A_MINSTRETH: if (XLEN == 32) rdata = XLEN'(minstret[63:32]);
        A_MHARTID:   rdata = HART_ID;
`ifdef CSR_TIMER_EN
        A_MTIME:     rdata = XLEN'(mtime);
        A_MTIMECMP:  rdata = XLEN'(mtimecmp);
        A_MTIMEH:    if (XLEN == 32) rdata = XLEN'(mtime[63:32]);
        A_MTIMECMPH: if (XLEN == 32) rdata = XLEN'(mtimecmp[63:32]);
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_csr_unit.sv
// Bench for csr_unit: a behavioural CSR model checked every cycle, plus directed literal checks.
module tb_csr_unit;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [11:0] raddr, waddr;
  logic [31:0] rdata, wdata, trap_cause, trap_pc, trap_tval, trap_target, mepc_o, irq_cause;
  logic        rillegal, we, trap_valid, mret, retire, ext_irq, sw_irq, irq_pending;
  logic [11:0] raddr2;
  logic [63:0] rdata2, target2, mepc2, cause2;
  logic        rill2, pend2;
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  csr_unit #(.XLEN(32), .MTVEC_RST(32'h100), .HART_ID(32'd5)) dut (
    .clk(clk), .rst_n(rst_n), .raddr(raddr), .rdata(rdata), .rillegal(rillegal),
    .we(we), .waddr(waddr), .wdata(wdata), .trap_valid(trap_valid), .trap_cause(trap_cause),
    .trap_pc(trap_pc), .trap_tval(trap_tval), .mret(mret), .retire(retire),
    .ext_irq(ext_irq), .sw_irq(sw_irq), .trap_target(trap_target), .mepc_o(mepc_o),
    .irq_pending(irq_pending), .irq_cause(irq_cause)
  );

  csr_unit #(.XLEN(64)) dut64 (
    .clk(clk), .rst_n(rst_n), .raddr(raddr2), .rdata(rdata2), .rillegal(rill2),
    .we(1'b0), .waddr(12'h0), .wdata(64'h0), .trap_valid(1'b0), .trap_cause(64'h0),
    .trap_pc(64'h0), .trap_tval(64'h0), .mret(1'b0), .retire(1'b0),
    .ext_irq(1'b0), .sw_irq(1'b0), .trap_target(target2), .mepc_o(mepc2),
    .irq_pending(pend2), .irq_cause(cause2)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Behavioural model of the architectural CSR state.
  bit          m_ie, m_pie, m_meip, m_msip, m_mtip;
  logic [31:0] m_mie, m_mtvec, m_mscr, m_mepc, m_mcause, m_mtval;
  logic [63:0] m_cyc, m_ins, m_time, m_tcmp;

  function automatic bit impl(input logic [11:0] a);
    case (a)
      12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343, 12'h344,
      12'hB00, 12'hB02, 12'hB80, 12'hB82, 12'hF14: return 1'b1;
`ifdef CSR_TIMER_EN
      12'h7C0, 12'h7C1, 12'h7C2, 12'h7C3: return 1'b1;
`endif
      default: return 1'b0;
    endcase
  endfunction

  function automatic bit writable(input logic [11:0] a);
    return impl(a) && a != 12'h344 && a != 12'hF14;
  endfunction

  function automatic logic [31:0] mask(input logic [11:0] a, input logic [31:0] d);
    if (a == 12'h300) return d & 32'h88;
    if (a == 12'h304) return d & 32'h888;
    if (a == 12'h341) return d & 32'hFFFF_FFFC;
    return d;
  endfunction

  function automatic logic [31:0] mip_word();
    return (m_meip ? 32'h800 : 32'h0) | (m_mtip ? 32'h80 : 32'h0) | (m_msip ? 32'h8 : 32'h0);
  endfunction

  function automatic logic [31:0] mread(input logic [11:0] a);
    case (a)
      12'h300: return (m_pie ? 32'h80 : 32'h0) | (m_ie ? 32'h8 : 32'h0);
      12'h304: return m_mie;
      12'h305: return m_mtvec;
      12'h340: return m_mscr;
      12'h341: return m_mepc;
      12'h342: return m_mcause;
      12'h343: return m_mtval;
      12'h344: return mip_word();
      12'hB00: return m_cyc[31:0];
      12'hB80: return m_cyc[63:32];
      12'hB02: return m_ins[31:0];
      12'hB82: return m_ins[63:32];
      12'hF14: return 32'd5;
`ifdef CSR_TIMER_EN
      12'h7C0: return m_time[31:0];
      12'h7C1: return m_time[63:32];
      12'h7C2: return m_tcmp[31:0];
      12'h7C3: return m_tcmp[63:32];
`endif
      default: return 32'h0;
    endcase
  endfunction

  function automatic bit blocked(input logic [11:0] a);
    if (trap_valid) return a inside {12'h300, 12'h341, 12'h342, 12'h343};
    if (mret) return a == 12'h300;
    return 1'b0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ie <= 0; m_pie <= 0; m_meip <= 0; m_msip <= 0; m_mtip <= 0;
      m_mie <= 0; m_mtvec <= 32'h100; m_mscr <= 0; m_mepc <= 0; m_mcause <= 0; m_mtval <= 0;
      m_cyc <= 0; m_ins <= 0; m_time <= 0; m_tcmp <= 0;
    end else begin
      m_meip <= ext_irq;
      m_msip <= sw_irq;
      if (trap_valid) begin
        m_mepc <= trap_pc & 32'hFFFF_FFFC; m_mcause <= trap_cause; m_mtval <= trap_tval;
        m_pie <= m_ie; m_ie <= 0;
      end else if (mret) begin
        m_ie <= m_pie; m_pie <= 1;
      end
      if (we && writable(waddr) && !blocked(waddr)) begin
        case (waddr)
          12'h300: begin m_ie <= wdata[3]; m_pie <= wdata[7]; end
          12'h304: m_mie <= wdata & 32'h888;
          12'h305: m_mtvec <= wdata;
          12'h340: m_mscr <= wdata;
          12'h341: m_mepc <= wdata & 32'hFFFF_FFFC;
          12'h342: m_mcause <= wdata;
          12'h343: m_mtval <= wdata;
          default: ;
        endcase
      end
      if (we && waddr == 12'hB00)      m_cyc <= {m_cyc[63:32], wdata};
      else if (we && waddr == 12'hB80) m_cyc <= {wdata, m_cyc[31:0]};
      else                             m_cyc <= m_cyc + 1;
      if (we && waddr == 12'hB02)      m_ins <= {m_ins[63:32], wdata};
      else if (we && waddr == 12'hB82) m_ins <= {wdata, m_ins[31:0]};
      else if (retire)                 m_ins <= m_ins + 1;
`ifdef CSR_TIMER_EN
      m_mtip <= (m_time >= m_tcmp) && (m_tcmp != 0);
      if (we && waddr == 12'h7C0)      m_time <= {m_time[63:32], wdata};
      else if (we && waddr == 12'h7C1) m_time <= {wdata, m_time[31:0]};
      else                             m_time <= m_time + 1;
      if (we && waddr == 12'h7C2)      m_tcmp <= {m_tcmp[63:32], wdata};
      else if (we && waddr == 12'h7C3) m_tcmp <= {wdata, m_tcmp[31:0]};
`endif
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    logic [31:0] e_rd, e_pend_vec, e_cause, e_tgt, e_base;
    bit          e_pend;
    e_rd = (we && waddr == raddr && writable(raddr)) ? mask(raddr, wdata) : mread(raddr);
    e_pend_vec = m_mie & mip_word();
    e_pend = m_ie && (e_pend_vec != 0);
    e_cause = !e_pend ? 32'h0 : e_pend_vec[11] ? 32'h8000_000B :
              e_pend_vec[3] ? 32'h8000_0003 : 32'h8000_0007;
    e_base = m_mtvec & 32'hFFFF_FFFC;
    if (trap_valid)
      e_tgt = (m_mtvec[1:0] == 2'b01 && trap_cause[31]) ? e_base + (trap_cause << 2) : e_base;
    else if (mret)
      e_tgt = m_mepc;
    else
      e_tgt = e_base;
    chk("rdata", rdata, e_rd);
    chk("rillegal", rillegal, !impl(raddr));
    chk("trap_target", trap_target, e_tgt);
    chk("mepc_o", mepc_o, m_mepc);
    chk("irq_pending", irq_pending, e_pend);
    chk("irq_cause", irq_cause, e_cause);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    we = 1; waddr = a; wdata = d;
    tick();
    we = 0;
  endtask

  task automatic rd_chk(input string name, input logic [11:0] a, input logic [31:0] e);
    raddr = a;
    #1;
    chk(name, rdata, e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [11:0] sweep [19];
    sweep = '{12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343, 12'h344,
              12'hB00, 12'hB02, 12'hB80, 12'hB82, 12'hF14, 12'h7C0, 12'h7C1, 12'h7C2,
              12'h7C3, 12'h000, 12'hFFF};
    raddr = 0; waddr = 0; wdata = 0; we = 0; trap_valid = 0; trap_cause = 0; trap_pc = 0;
    trap_tval = 0; mret = 0; retire = 0; ext_irq = 0; sw_irq = 0; raddr2 = 12'hB80;
    tick(); tick();
    rd_chk("rst_mtvec", 12'h305, 32'h100);
    chk("rst_pend", irq_pending, 0);
    rst_n = 1;
    tick();

    rd_chk("mhartid", 12'hF14, 32'd5);
    raddr = 12'h7C0; #1;
`ifdef CSR_TIMER_EN
    chk("mtime_impl", rillegal, 0);
`else
    chk("mtime_ill", rillegal, 1);
    chk("mtime_zero", rdata, 0);
`endif
    raddr = 12'h123; #1;
    chk("ill_flag", rillegal, 1);
    chk("ill_data", rdata, 0);
    chk("rv64_mcycleh_ill", rill2, 1);
    chk("rv64_mcycleh_data", rdata2, 0);
    raddr2 = 12'hB00; #1;
    chk("rv64_mcycle_impl", rill2, 0);
    tick();

    // Enable MIE and MEIE, then raise the external interrupt.
    we = 1; waddr = 12'h300; wdata = 32'h88; raddr = 12'h300; #1;
    chk("bypass_mstatus", rdata, 32'h88);
    tick();
    waddr = 12'h304; wdata = 32'h800;
    tick();
    we = 0;
    rd_chk("mstatus", 12'h300, 32'h88);
    ext_irq = 1; #1;
    chk("irq_not_yet", irq_pending, 0);
    tick(); tick();
    chk("irq_pend", irq_pending, 1);
    chk("irq_cause_mei", irq_cause, 32'h8000_000B);
    sw_irq = 1;
    wr(12'h304, 32'hFFFF_FFFF);
    rd_chk("mie_mask", 12'h304, 32'h888);
    chk("irq_prio", irq_cause, 32'h8000_000B);
    ext_irq = 0;
    tick();
    chk("irq_cause_msi", irq_cause, 32'h8000_0003);
    sw_irq = 0;
    tick();
    chk("irq_clear", irq_pending, 0);

    // Vectored trap entry followed by mret.
    wr(12'h305, 32'h8000_0001);
    trap_valid = 1; trap_cause = 32'h8000_0007; trap_pc = 32'h1234; trap_tval = 32'h55; #1;
    chk("vec_target", trap_target, 32'h8000_001C);
    tick();
    trap_valid = 0;
    rd_chk("mepc", 12'h341, 32'h1234);
    chk("mepc_o_lit", mepc_o, 32'h1234);
    rd_chk("mstatus_trap", 12'h300, 32'h80);
    tick();
    mret = 1; #1;
    chk("mret_target", trap_target, 32'h1234);
    tick();
    mret = 0;
    rd_chk("mstatus_mret", 12'h300, 32'h88);

    // Trap, mret and mepc write in one cycle: only the trap lands.
    trap_valid = 1; trap_cause = 32'h2; trap_pc = 32'h2000; mret = 1;
    we = 1; waddr = 12'h341; wdata = 32'hDEAD_0000; #1;
    chk("direct_target", trap_target, 32'h8000_0000);
    tick();
    trap_valid = 0; mret = 0; we = 0;
    rd_chk("mepc_trap_wins", 12'h341, 32'h2000);
    rd_chk("mstatus_trap2", 12'h300, 32'h80);
    mret = 1; #1;
    chk("ret_to_trap_pc", trap_target, 32'h2000);
    tick();
    mret = 0;
    mret = 1; we = 1; waddr = 12'h300; wdata = 32'h0;
    tick();
    mret = 0; we = 0;
    rd_chk("mret_beats_we", 12'h300, 32'h88);
    trap_valid = 1; trap_cause = 32'h5; trap_pc = 32'h3000; we = 1; waddr = 12'h340; wdata = 32'hABCD;
    tick();
    trap_valid = 0; we = 0;
    rd_chk("mscratch_kept", 12'h340, 32'hABCD);
    mret = 1;
    tick();
    mret = 0;
    wr(12'h341, 32'h1237);
    rd_chk("mepc_align", 12'h341, 32'h1234);

    // 64-bit mcycle wrap through both halves.
    wr(12'hB00, 32'hFFFF_FFFF);
    wr(12'hB80, 32'hFFFF_FFFF);
    rd_chk("mcycle_held", 12'hB00, 32'hFFFF_FFFF);
    tick();
    rd_chk("mcycle_wrap_lo", 12'hB00, 32'h0);
    rd_chk("mcycle_wrap_hi", 12'hB80, 32'h0);
    tick();

    // Address sweep with alternating retire pulses.
    for (int i = 0; i < 19; i++) begin
      raddr = sweep[i];
      retire = i[0];
      tick();
    end
    retire = 0;
    rd_chk("minstret", 12'hB02, 32'd9);
    tick();

`ifdef CSR_TIMER_EN
    wr(12'h7C2, 32'd20);
    raddr = 12'h344;
    #1;
    for (int k = 0; k < 40 && rdata[7] !== 1'b1; k++) tick();
    chk("mtip", rdata[7], 1);
    chk("mti_cause", irq_cause, 32'h8000_0007);
    rd_chk("mtimecmp", 12'h7C2, 32'd20);
    tick();
`endif

    // Asynchronous reset mid-run, observed before any clock edge.
    sw_irq = 1;
    tick(); tick();
    chk("pre_rst_pend", irq_pending, 1);
    raddr = 12'h305;
    @(posedge clk);
    #3;
    rst_n = 0;
    #1;
    chk("async_mtvec", rdata, 32'h100);
    chk("async_pend", irq_pending, 0);
    chk("async_cause", irq_cause, 0);
    chk("async_mepc", mepc_o, 0);
    raddr = 12'hB00; #1;
    chk("async_mcycle", rdata, 0);
    sw_irq = 0;
    tick(); tick();
    rst_n = 1;
    tick(); tick(); tick();
    rd_chk("mcycle_after_rst", 12'hB00, 32'd3);
    repeat (3) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
